// File: rtl/reg_alu_pkg.sv
// Shared types for the register-file + ALU execution unit.
// REG_ALU_MUL_EN adds the iterative multiply state.
package reg_alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpAnd  = 4'd2,
    OpOr   = 4'd3,
    OpXor  = 4'd4,
    OpSll  = 4'd5,
    OpSrl  = 4'd6,
    OpSra  = 4'd7,
    OpSlt  = 4'd8,
    OpSltu = 4'd9,
    OpMul  = 4'd10
  } alu_op_t;

`ifdef REG_ALU_MUL_EN
  typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_t;
`else
  typedef enum logic [1:0] {StIdle, StExec, StResp} state_t;
`endif

endpackage

// File: rtl/reg_alu_unit_alu_core.sv
// Combinational ALU: result, operand equality and illegal-opcode flag.
// With REG_ALU_MUL_EN the multiply is sequenced by the caller; MUL is legal here but yields 0.
module alu_core
  import reg_alu_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [D_WIDTH-1:0]  op1,
  input  logic [D_WIDTH-1:0]  op2,
  output logic [D_WIDTH-1:0]  result,
  output logic                eq,
  output logic                illegal
);

  localparam int unsigned SH_W = $clog2(D_WIDTH);

  logic [SH_W-1:0] shamt;

  assign shamt = op2[SH_W-1:0];
  assign eq    = (op1 == op2);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    unique case (op)
      OpAdd:  result = op1 + op2;
      OpSub:  result = op1 - op2;
      OpAnd:  result = op1 & op2;
      OpOr:   result = op1 | op2;
      OpXor:  result = op1 ^ op2;
      OpSll:  result = op1 << shamt;
      OpSrl:  result = op1 >> shamt;
      OpSra:  result = D_WIDTH'($signed(op1) >>> shamt);
      OpSlt:  result = D_WIDTH'($signed(op1) < $signed(op2));
      OpSltu: result = D_WIDTH'(op1 < op2);
`ifdef REG_ALU_MUL_EN
      OpMul:  result = '0;
`else
      OpMul:  illegal = 1'b1;
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_alu_unit.sv
// Handshaked register file + ALU unit: one operation in flight, registered response.
// REG_ALU_MUL_EN enables the D_WIDTH-cycle shift-add multiplier for opcode 10.
module reg_alu_unit
  import reg_alu_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 5,
  parameter int unsigned A0_IDX  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ALU_OP_W-1:0] req_op,
  input  logic [A_WIDTH-1:0]  req_rd,
  input  logic [A_WIDTH-1:0]  req_rs1,
  input  logic [A_WIDTH-1:0]  req_rs2,
  input  logic [D_WIDTH-1:0]  req_imm,
  input  logic                req_use_imm,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [D_WIDTH-1:0]  resp_data,
  output logic                resp_eq,
  output logic                resp_err,
  output logic [D_WIDTH-1:0]  a0
);

  localparam int unsigned NREGS = 2 ** A_WIDTH;
  localparam logic [A_WIDTH-1:0] A0_ADDR = A_WIDTH'(A0_IDX);

  state_t              state;
  logic [ALU_OP_W-1:0] op_q;
  logic [A_WIDTH-1:0]  rd_q;
  logic [D_WIDTH-1:0]  op1_q, op2_q;
  logic [D_WIDTH-1:0]  regs [NREGS];

  logic [D_WIDTH-1:0]  rs1_val, rs2_val;
  logic [D_WIDTH-1:0]  alu_result;
  logic                alu_eq, alu_illegal;

  assign rs1_val = (req_rs1 == '0) ? '0 : regs[req_rs1];
  assign rs2_val = (req_rs2 == '0) ? '0 : regs[req_rs2];
  assign a0      = regs[A0_ADDR];

  alu_core #(
    .D_WIDTH (D_WIDTH)
  ) u_alu_core (
    .op      (op_q),
    .op1     (op1_q),
    .op2     (op2_q),
    .result  (alu_result),
    .eq      (alu_eq),
    .illegal (alu_illegal)
  );

`ifdef REG_ALU_MUL_EN
  localparam int unsigned CNT_W = $clog2(D_WIDTH);

  logic [D_WIDTH-1:0] mul_acc, mul_mcand, mul_mplier, mul_acc_nxt;
  logic [CNT_W-1:0]   mul_cnt;

  assign mul_acc_nxt = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_eq    <= 1'b0;
      resp_err   <= 1'b0;
      op_q       <= '0;
      rd_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
`ifdef REG_ALU_MUL_EN
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            op_q      <= req_op;
            rd_q      <= req_rd;
            op1_q     <= rs1_val;
            op2_q     <= req_use_imm ? req_imm : rs2_val;
            req_ready <= 1'b0;
            state     <= StExec;
          end
        end
        StExec: begin
`ifdef REG_ALU_MUL_EN
          if (op_q == OpMul) begin
            mul_acc    <= '0;
            mul_mcand  <= op1_q;
            mul_mplier <= op2_q;
            mul_cnt    <= '0;
            state      <= StMul;
          end else
`endif
          begin
            // Register 0 is never written so it keeps reading as zero.
            if (!alu_illegal && rd_q != '0) regs[rd_q] <= alu_result;
            resp_data  <= alu_result;
            resp_eq    <= alu_eq;
            resp_err   <= alu_illegal;
            resp_valid <= 1'b1;
            state      <= StResp;
          end
        end
`ifdef REG_ALU_MUL_EN
        StMul: begin
          mul_acc    <= mul_acc_nxt;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + 1'b1;
          if (mul_cnt == CNT_W'(D_WIDTH - 1)) begin
            if (rd_q != '0) regs[rd_q] <= mul_acc_nxt;
            resp_data  <= mul_acc_nxt;
            resp_eq    <= alu_eq;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= StResp;
          end
        end
`endif
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_alu_unit.sv
// Randomised self-checking bench for reg_alu_unit against a behavioural register/ALU model.
module tb_reg_alu_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [4:0]  req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [31:0] req_imm = '0;
  logic        req_use_imm = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        resp_eq, resp_err;
  logic [31:0] a0;

  always #5 clk = ~clk;

  reg_alu_unit #(
    .D_WIDTH (32),
    .A_WIDTH (5),
    .A0_IDX  (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_imm     (req_imm),
    .req_use_imm (req_use_imm),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_eq     (resp_eq),
    .resp_err    (resp_err),
    .a0          (a0)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mregs [32];
  logic [31:0] exp_data;
  logic [4:0]  exp_rd;
  bit          exp_eq, exp_err;
  bit          pending = 0;
  bit          active = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Expected result of one operation from plain arithmetic on the operands.
  function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit err);
    int sh;
    sh  = int'(b % 32);
    r   = '0;
    err = 0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = a << sh;
      6: r = a >> sh;
      7: r = (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: r = (a < b) ? 32'd1 : 32'd0;
`ifdef REG_ALU_MUL_EN
      10: r = a * b;
`endif
      default: err = 1;
    endcase
  endfunction

  function automatic int exp_lat(input int op);
`ifdef REG_ALU_MUL_EN
    if (op == 10) return 2 + 32;
`endif
    return 2;
  endfunction

  // One clock: advance to the next falling edge, update the model, compare every output.
  task automatic tick();
    bit hs, acc, in_rst;
    hs     = resp_valid && resp_ready;
    acc    = req_valid && req_ready;
    in_rst = rst;
    @(negedge clk);
    if (in_rst) begin
      for (int i = 0; i < 32; i++) mregs[i] = '0;
      pending = 0;
      active  = 0;
      return;
    end
    if (hs) active = 0;
    if (acc) pending = 1;
    if (resp_valid) begin
      if (pending) begin
        pending = 0;
        active  = 1;
        if (!exp_err && exp_rd != 0) mregs[exp_rd] = exp_data;
      end
      chk("resp_valid_expected", {31'b0, active}, 32'd1);
      if (active) begin
        chk("resp_data", resp_data, exp_data);
        chk("resp_eq", {31'b0, resp_eq}, {31'b0, exp_eq});
        chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
      end
    end
    chk("a0", a0, mregs[10]);
  endtask

  task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm, input bit use_imm, input int hold,
                       output logic [31:0] got, output bit got_err);
    logic [31:0] a, b;
    int lat;
    a = mregs[rs1];
    b = use_imm ? imm : mregs[rs2];
    model(op, a, b, exp_data, exp_err);
    exp_eq = (a == b);
    exp_rd = rd[4:0];
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_op      = op[3:0];
    req_rd      = rd[4:0];
    req_rs1     = rs1[4:0];
    req_rs2     = rs2[4:0];
    req_imm     = imm;
    req_use_imm = use_imm;
    resp_ready  = (hold == 0);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat(op));
    got     = resp_data;
    got_err = resp_err;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      req_op    = 4'd0;
      req_rd    = 5'd13;
      req_imm   = 32'h55;
      tick();
      chk("stall_data", resp_data, got);
      chk("stall_valid", {31'b0, resp_valid}, 32'd1);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    chk("post_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("post_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    bit          gerr;
    for (int i = 0; i < 32; i++) mregs[i] = '0;

    tick();
    tick();
    rst = 1'b0;
    chk("reset_a0", a0, 32'd0);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    tick();

    issue(0, 1, 5, 0, 32'd0, 1, 0, got, gerr);
    chk("lit_read_r5", got, 32'd0);
    issue(0, 10, 0, 0, 32'd7, 1, 0, got, gerr);
    chk("lit_add7", got, 32'd7);
    issue(0, 10, 10, 0, 32'd3, 1, 0, got, gerr);
    chk("lit_add10", got, 32'd10);
    chk("lit_a0_10", a0, 32'd10);

    issue(1, 2, 0, 0, 32'd1, 1, 0, got, gerr);
    chk("lit_sub", got, 32'hFFFF_FFFF);
    issue(8, 3, 2, 0, 32'd0, 1, 0, got, gerr);
    chk("lit_slt", got, 32'd1);
    issue(9, 3, 2, 0, 32'd0, 1, 0, got, gerr);
    chk("lit_sltu", got, 32'd0);
    issue(7, 4, 2, 0, 32'd4, 1, 0, got, gerr);
    chk("lit_sra", got, 32'hFFFF_FFFF);

    issue(0, 5, 0, 0, 32'h1234, 1, 5, got, gerr);
    chk("lit_stall_data", got, 32'h1234);
    issue(0, 0, 0, 0, 32'd5, 1, 0, got, gerr);
    chk("lit_rd0_resp", got, 32'd5);
    issue(0, 7, 0, 0, 32'd0, 0, 0, got, gerr);
    chk("lit_r0_reads0", got, 32'd0);

    issue(12, 10, 10, 0, 32'd1, 1, 0, got, gerr);
    chk("lit_illegal_err", {31'b0, gerr}, 32'd1);
    chk("lit_illegal_data", got, 32'd0);
    chk("lit_illegal_nowrite", a0, 32'd10);

    issue(0, 11, 0, 0, 32'd6, 1, 0, got, gerr);
    issue(10, 12, 11, 0, 32'd7, 1, 0, got, gerr);
`ifdef REG_ALU_MUL_EN
    chk("lit_mul", got, 32'd42);
    chk("lit_mul_err", {31'b0, gerr}, 32'd0);
`else
    chk("lit_mul_illegal", {31'b0, gerr}, 32'd1);
`endif

    // Abort an ADD in EXEC: no write, no response, registers cleared.
    issue(0, 6, 0, 0, 32'd99, 1, 0, got, gerr);
    req_valid   = 1'b1;
    req_op      = 4'd0;
    req_rd      = 5'd6;
    req_rs1     = 5'd6;
    req_imm     = 32'd9;
    req_use_imm = 1'b1;
    exp_data = 32'd108;
    exp_err  = 0;
    exp_eq   = 0;
    exp_rd   = 5'd6;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    tick();
    chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
    issue(0, 1, 6, 0, 32'd0, 1, 0, got, gerr);
    chk("lit_abort_r6", got, 32'd0);

    for (int n = 0; n < 120; n++) begin
      int op, hold;
      op   = (n % 4 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      issue(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? 32'h8000_0000 | $urandom_range(0, 40) : $urandom,
            bit'($urandom_range(0, 1)), hold, got, gerr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
